keypad_entry_collector: RTL and testbench

- Parameterised ASCII key-entry collector placed between the keyboard/UART ASCII decoder and the ATM control FSM.
- Arms on a start strobe and collects one entry in a latched mode: account/PIN/amount digits, menu letter, currency digit, or Enter-only.
- Adds backspace, a minimum-length check, a configurable digit count, an echo stream (masked for PIN) and a one-cycle completion handshake.

---
 rtl/keypad_entry_collector.sv | 176 +++++++++++++++++
 tb/tb_keypad_entry_collector.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_entry_collector.sv
// Keypad entry collector: gathers one ASCII key entry (digits, menu letter,
// currency digit or Enter only) for the ATM controller. It supports backspace,
// a minimum-length check, a masked echo stream and a one-cycle done pulse.
module keypad_entry_collector #(
   parameter int MAX_DIGITS = 8,
   parameter int MIN_DIGITS = 4,
   parameter int CNT_W      = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [3:0]              mode_in,
   input  logic                    key_valid,
   input  logic [7:0]              key_code,
   output logic                    busy,
   output logic                    done,
   output logic [3:0]              status_code_out,
   output logic [4*MAX_DIGITS-1:0] value,
   output logic [CNT_W-1:0]        digit_count,
   output logic [1:0]              usr_input_out,
   output logic [2:0]              currency_type_out,
   output logic                    key_err,
   output logic                    echo_valid,
   output logic [7:0]              echo_char
);

   localparam int VAL_W = 4*MAX_DIGITS;
   localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_DIGITS);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DIGITS);

   localparam logic [3:0] ST_EXIT     = 4'b0111;
   localparam logic [3:0] ST_COMPLETE = 4'b1000;

   localparam logic [3:0] M_ACC  = 4'd2;
   localparam logic [3:0] M_PIN  = 4'd3;
   localparam logic [3:0] M_MENU = 4'd4;
   localparam logic [3:0] M_CURR = 4'd5;
   localparam logic [3:0] M_AMT  = 4'd6;

   localparam logic [7:0] KEY_QUIT  = 8'h71;
   localparam logic [7:0] KEY_ENTER = 8'h0D;
   localparam logic [7:0] KEY_BKSP  = 8'h08;
   localparam logic [7:0] KEY_STAR  = 8'h2A;

   typedef enum logic {IDLE, COLLECT} state_t;

   state_t                state, state_nxt;
   logic [3:0]            mode_q, mode_nxt;
   logic                  sel_q, sel_nxt;
   logic [VAL_W-1:0]      value_nxt;
   logic [CNT_W-1:0]      count_nxt;
   logic [1:0]            usr_nxt;
   logic [2:0]            cur_nxt;
   logic [3:0]            status_nxt;
   logic                  done_nxt, err_nxt, echo_v_nxt;
   logic [7:0]            echo_c_nxt;

   logic is_numeric, is_digit, is_curr_key, enter_ok;

   assign busy        = (state == COLLECT);
   assign is_numeric  = (mode_q == M_ACC) || (mode_q == M_PIN) || (mode_q == M_AMT);
   assign is_digit    = (key_code >= 8'h30) && (key_code <= 8'h39);
   assign is_curr_key = (key_code >= 8'h31) && (key_code <= 8'h35);
   // Numeric modes need enough digits, selection modes need a choice, the rest always accept Enter.
   assign enter_ok    = is_numeric ? (digit_count >= MIN_CNT) :
                        ((mode_q == M_MENU) || (mode_q == M_CURR)) ? sel_q : 1'b1;

   // Next-state and next-output decode; start always wins over a key in the same cycle.
   always_comb begin
      state_nxt  = state;
      mode_nxt   = mode_q;
      sel_nxt    = sel_q;
      value_nxt  = value;
      count_nxt  = digit_count;
      usr_nxt    = usr_input_out;
      cur_nxt    = currency_type_out;
      status_nxt = status_code_out;
      done_nxt   = 1'b0;
      err_nxt    = 1'b0;
      echo_v_nxt = 1'b0;
      echo_c_nxt = echo_char;
      if (start) begin
         state_nxt  = COLLECT;
         mode_nxt   = mode_in;
         sel_nxt    = 1'b0;
         value_nxt  = '0;
         count_nxt  = '0;
         status_nxt = 4'd0;
      end else if (state == COLLECT && key_valid) begin
         if (key_code == KEY_QUIT) begin
            status_nxt = ST_EXIT;
            done_nxt   = 1'b1;
            state_nxt  = IDLE;
         end else if (key_code == KEY_ENTER) begin
            if (enter_ok) begin
               status_nxt = ST_COMPLETE;
               done_nxt   = 1'b1;
               state_nxt  = IDLE;
            end else begin
               err_nxt = 1'b1;
            end
         end else if (key_code == KEY_BKSP && is_numeric) begin
            if (digit_count != '0) begin
               value_nxt = {4'd0, value[VAL_W-1:4]};
               count_nxt = digit_count - 1'b1;
            end else begin
               err_nxt = 1'b1;
            end
         end else if (is_digit && is_numeric) begin
            if (digit_count < MAX_CNT) begin
               value_nxt  = {value[VAL_W-5:0], key_code[3:0]};
               count_nxt  = digit_count + 1'b1;
               echo_v_nxt = 1'b1;
               echo_c_nxt = (mode_q == M_PIN) ? KEY_STAR : key_code;
            end else begin
               err_nxt = 1'b1;
            end
         end else if (mode_q == M_MENU) begin
            sel_nxt    = 1'b1;
            echo_v_nxt = 1'b1;
            echo_c_nxt = key_code;
            case (key_code)
               8'h62:   usr_nxt = 2'b00;
               8'h63:   usr_nxt = 2'b01;
               8'h77:   usr_nxt = 2'b10;
               8'h74:   usr_nxt = 2'b11;
               default: begin
                  sel_nxt    = sel_q;
                  echo_v_nxt = 1'b0;
                  echo_c_nxt = echo_char;
                  err_nxt    = 1'b1;
               end
            endcase
         end else if (mode_q == M_CURR && is_curr_key) begin
            cur_nxt    = key_code[2:0] - 3'd1;
            sel_nxt    = 1'b1;
            echo_v_nxt = 1'b1;
            echo_c_nxt = key_code;
         end else begin
            err_nxt = 1'b1;
         end
      end
   end

   // State and output registers; reset clears everything and drops any entry in progress.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state             <= IDLE;
         mode_q            <= 4'd0;
         sel_q             <= 1'b0;
         value             <= '0;
         digit_count       <= '0;
         usr_input_out     <= 2'd0;
         currency_type_out <= 3'd0;
         status_code_out   <= 4'd0;
         done              <= 1'b0;
         key_err           <= 1'b0;
         echo_valid        <= 1'b0;
         echo_char         <= 8'd0;
      end else begin
         state             <= state_nxt;
         mode_q            <= mode_nxt;
         sel_q             <= sel_nxt;
         value             <= value_nxt;
         digit_count       <= count_nxt;
         usr_input_out     <= usr_nxt;
         currency_type_out <= cur_nxt;
         status_code_out   <= status_nxt;
         done              <= done_nxt;
         key_err           <= err_nxt;
         echo_valid        <= echo_v_nxt;
         echo_char         <= echo_c_nxt;
      end
   end

endmodule

// File: tb/tb_keypad_entry_collector.sv
// Bench for keypad_entry_collector: directed scenarios plus a randomized run
// checked against a queue-based model of the entry rules.
module tb_keypad_entry_collector;

   localparam int MAXD = 8;
   localparam int MIND = 4;
   localparam int CW   = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic [3:0] mode_in = 4'd0;
   logic key_valid = 1'b0;
   logic [7:0] key_code = 8'd0;
   logic busy, done, key_err, echo_valid;
   logic [3:0] status_code_out;
   logic [4*MAXD-1:0] value;
   logic [CW-1:0] digit_count;
   logic [1:0] usr_input_out;
   logic [2:0] currency_type_out;
   logic [7:0] echo_char;

   int tests = 0;
   int fails = 0;

   keypad_entry_collector #(.MAX_DIGITS(MAXD), .MIN_DIGITS(MIND), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mode_in(mode_in),
      .key_valid(key_valid), .key_code(key_code), .busy(busy), .done(done),
      .status_code_out(status_code_out), .value(value), .digit_count(digit_count),
      .usr_input_out(usr_input_out), .currency_type_out(currency_type_out),
      .key_err(key_err), .echo_valid(echo_valid), .echo_char(echo_char)
   );

   always #5 clk = ~clk;

   // Behavioural model: entry kept as a queue of digits, oldest first.
   bit         m_busy = 0;
   logic [3:0] m_mode = 0;
   logic [3:0] m_digits[$];
   bit         m_sel = 0;
   logic [1:0] m_usr = 0;
   logic [2:0] m_cur = 0;
   logic [3:0] m_status = 0;
   bit         e_done, e_err, e_echo;
   logic [7:0] e_char;

   function automatic logic [4*MAXD-1:0] model_value();
      logic [4*MAXD-1:0] v = '0;
      foreach (m_digits[i]) v = (v << 4) | {{(4*MAXD-4){1'b0}}, m_digits[i]};
      return v;
   endfunction

   task automatic model_step(input logic s, input logic [3:0] m, input logic kv, input logic [7:0] kc);
      bit numeric;
      e_done = 0; e_err = 0; e_echo = 0;
      numeric = (m_mode == 2) || (m_mode == 3) || (m_mode == 6);
      if (!rst_n) begin
         m_busy = 0; m_mode = 0; m_digits.delete(); m_sel = 0;
         m_usr = 0; m_cur = 0; m_status = 0;
      end else if (s) begin
         m_busy = 1; m_mode = m; m_digits.delete(); m_sel = 0; m_status = 0;
      end else if (m_busy && kv) begin
         if (kc == "q") begin
            m_status = 4'd7; e_done = 1; m_busy = 0;
         end else if (kc == 8'h0D) begin
            bit ok;
            if (numeric) ok = (m_digits.size() >= MIND);
            else if (m_mode == 4 || m_mode == 5) ok = m_sel;
            else ok = 1;
            if (ok) begin m_status = 4'd8; e_done = 1; m_busy = 0; end
            else e_err = 1;
         end else if (kc == 8'h08 && numeric) begin
            if (m_digits.size() > 0) void'(m_digits.pop_back());
            else e_err = 1;
         end else if (kc >= "0" && kc <= "9" && numeric) begin
            if (m_digits.size() < MAXD) begin
               m_digits.push_back(4'(kc - 8'h30));
               e_echo = 1; e_char = (m_mode == 3) ? 8'h2A : kc;
            end else e_err = 1;
         end else if (m_mode == 4 && (kc == "b" || kc == "c" || kc == "w" || kc == "t")) begin
            m_usr = (kc == "b") ? 2'd0 : (kc == "c") ? 2'd1 : (kc == "w") ? 2'd2 : 2'd3;
            m_sel = 1; e_echo = 1; e_char = kc;
         end else if (m_mode == 5 && kc >= "1" && kc <= "5") begin
            m_cur = 3'(kc - 8'h31); m_sel = 1; e_echo = 1; e_char = kc;
         end else e_err = 1;
      end
   endtask

   // One clock: drive at negedge, update model at posedge, leave outputs ready to sample.
   task automatic apply(input logic s, input logic [3:0] m, input logic kv, input logic [7:0] kc);
      @(negedge clk);
      start = s; mode_in = m; key_valid = kv; key_code = kc;
      @(posedge clk);
      model_step(s, m, kv, kc);
      #1;
   endtask

   task automatic key(input logic [7:0] kc);
      apply(0, 4'd0, 1, kc);
   endtask

   task automatic test_reset();
      rst_n = 0;
      apply(0, 0, 0, 0);
      apply(0, 0, 1, "1");
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b exp 0", done); end
      tests++; if (status_code_out !== 4'd0) begin fails++; $display("FAIL reset_status got %h exp 0", status_code_out); end
      tests++; if (value !== '0) begin fails++; $display("FAIL reset_value got %h exp 0", value); end
      tests++; if (digit_count !== '0) begin fails++; $display("FAIL reset_count got %0d exp 0", digit_count); end
      tests++; if ({key_err, echo_valid, usr_input_out, currency_type_out, echo_char} !== '0) begin
         fails++; $display("FAIL reset_misc got %b exp 0", {key_err, echo_valid, usr_input_out, currency_type_out, echo_char}); end
      rst_n = 1;
      apply(0, 0, 0, 0);
   endtask

   task automatic test_acc_number();
      apply(1, 4'd2, 0, 0);
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL acc_busy got %b exp 1", busy); end
      key("1"); key("2"); key("3"); key("4");
      tests++; if (echo_valid !== 1'b1 || echo_char !== "4") begin fails++; $display("FAIL acc_echo got %b/%h exp 1/34", echo_valid, echo_char); end
      key(8'h0D);
      tests++; if (done !== 1'b1) begin fails++; $display("FAIL acc_done got %b exp 1", done); end
      tests++; if (value[15:0] !== 16'h1234) begin fails++; $display("FAIL acc_value got %h exp 1234", value[15:0]); end
      tests++; if (digit_count !== 4'd4) begin fails++; $display("FAIL acc_count got %0d exp 4", digit_count); end
      tests++; if (status_code_out !== 4'b1000) begin fails++; $display("FAIL acc_status got %b exp 1000", status_code_out); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL acc_busy_done got %b exp 0", busy); end
      apply(0, 0, 0, 0);
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL acc_done_pulse got %b exp 0", done); end
      tests++; if (value[15:0] !== 16'h1234 || status_code_out !== 4'b1000) begin
         fails++; $display("FAIL acc_hold got %h/%b exp 1234/1000", value[15:0], status_code_out); end
   endtask

   task automatic test_pin();
      logic [7:0] ks[4] = '{"9", "8", "7", "6"};
      apply(1, 4'd3, 0, 0);
      for (int i = 0; i < 4; i++) begin
         key(ks[i]);
         tests++; if (echo_valid !== 1'b1 || echo_char !== 8'h2A) begin
            fails++; $display("FAIL pin_echo got %b/%h exp 1/2a", echo_valid, echo_char); end
         if (i == 1) begin
            key(8'h0D);
            tests++; if (key_err !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
               fails++; $display("FAIL pin_short got err%b busy%b done%b exp 1 1 0", key_err, busy, done); end
         end
      end
      key(8'h0D);
      tests++; if (done !== 1'b1 || value[15:0] !== 16'h9876) begin
         fails++; $display("FAIL pin_value got %b/%h exp 1/9876", done, value[15:0]); end
   endtask

   task automatic test_backspace();
      apply(1, 4'd6, 0, 0);
      key("5"); key("6"); key(8'h08);
      tests++; if (echo_valid !== 1'b0) begin fails++; $display("FAIL bs_no_echo got %b exp 0", echo_valid); end
      key("7");
      tests++; if (value !== 32'h57 || digit_count !== 4'd2) begin
         fails++; $display("FAIL bs_value got %h/%0d exp 57/2", value, digit_count); end
      key(8'h08); key(8'h08);
      tests++; if (key_err !== 1'b0 || digit_count !== 4'd0) begin
         fails++; $display("FAIL bs_second got err%b cnt%0d exp 0 0", key_err, digit_count); end
      key(8'h08);
      tests++; if (key_err !== 1'b1 || digit_count !== 4'd0 || value !== '0) begin
         fails++; $display("FAIL bs_empty got err%b cnt%0d v%h exp 1 0 0", key_err, digit_count, value); end
   endtask

   task automatic test_overflow_and_reset();
      apply(1, 4'd2, 0, 0);
      for (int i = 1; i <= 9; i++) begin
         key(8'h30 + 8'(i));
         if (i == 8) begin
            tests++; if (key_err !== 1'b0) begin fails++; $display("FAIL ovf_eighth got %b exp 0", key_err); end
         end
      end
      tests++; if (key_err !== 1'b1 || echo_valid !== 1'b0) begin
         fails++; $display("FAIL ovf_ninth got err%b echo%b exp 1 0", key_err, echo_valid); end
      tests++; if (value !== 32'h12345678 || digit_count !== 4'd8) begin
         fails++; $display("FAIL ovf_value got %h/%0d exp 12345678/8", value, digit_count); end
      rst_n = 0;
      apply(0, 0, 1, 8'h0D);
      rst_n = 1;
      tests++; if ({busy, done, status_code_out, value, digit_count, key_err, echo_valid} !== '0) begin
         fails++; $display("FAIL midreset got busy%b done%b st%h v%h cnt%0d exp all 0", busy, done, status_code_out, value, digit_count); end
      apply(0, 0, 0, 0);
      tests++; if (done !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL midreset_after got done%b busy%b exp 0 0", done, busy); end
   endtask

   task automatic test_menu_currency();
      apply(1, 4'd4, 0, 0);
      key(8'h0D);
      tests++; if (key_err !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL menu_nosel got err%b done%b exp 1 0", key_err, done); end
      key("w");
      tests++; if (usr_input_out !== 2'b10 || echo_char !== "w") begin fails++; $display("FAIL menu_w got %b/%h exp 10/77", usr_input_out, echo_char); end
      key("t"); key(8'h0D);
      tests++; if (usr_input_out !== 2'b11 || done !== 1'b1) begin fails++; $display("FAIL menu_t got %b/%b exp 11/1", usr_input_out, done); end
      apply(1, 4'd5, 0, 0);
      key("6");
      tests++; if (key_err !== 1'b1) begin fails++; $display("FAIL curr_bad got %b exp 1", key_err); end
      key("4"); key(8'h0D);
      tests++; if (currency_type_out !== 3'b011 || done !== 1'b1 || status_code_out !== 4'b1000) begin
         fails++; $display("FAIL curr_sel got %b/%b/%b exp 011/1/1000", currency_type_out, done, status_code_out); end
   endtask

   task automatic test_exit_and_drop();
      apply(1, 4'd6, 0, 0);
      key("1"); key("2"); key("q");
      tests++; if (status_code_out !== 4'b0111 || done !== 1'b1 || busy !== 1'b0) begin
         fails++; $display("FAIL exit got st%b done%b busy%b exp 0111 1 0", status_code_out, done, busy); end
      tests++; if (value !== 32'h12) begin fails++; $display("FAIL exit_value got %h exp 12", value); end
      key("5");
      tests++; if (key_err !== 1'b0 || echo_valid !== 1'b0 || done !== 1'b0) begin
         fails++; $display("FAIL idle_ignore got err%b echo%b done%b exp 0 0 0", key_err, echo_valid, done); end
      apply(1, 4'd2, 1, "5");
      tests++; if (busy !== 1'b1 || digit_count !== 4'd0 || echo_valid !== 1'b0) begin
         fails++; $display("FAIL drop_idle got busy%b cnt%0d echo%b exp 1 0 0", busy, digit_count, echo_valid); end
      key("3");
      apply(1, 4'd2, 1, "4");
      tests++; if (digit_count !== 4'd0 || value !== '0 || busy !== 1'b1) begin
         fails++; $display("FAIL drop_collect got cnt%0d v%h busy%b exp 0 0 1", digit_count, value, busy); end
   endtask

   task automatic test_random();
      logic [7:0] pool[18] = '{"0","1","2","3","4","5","6","7","8","9",
                               8'h0D, 8'h08, "b", "c", "w", "t", "q", "x"};
      logic prev_done = 0;
      for (int n = 0; n < 3000; n++) begin
         int r = $urandom_range(0, 199);
         logic s;
         rst_n = (r != 0);
         s = m_busy ? (r < 6) : (r < 80);
         apply(s, 4'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0), pool[$urandom_range(0, 17)]);
         tests++; if ({done, key_err, echo_valid, busy} !== {e_done, e_err, e_echo, m_busy}) begin
            fails++; $display("FAIL rnd_ctrl got %b exp %b", {done, key_err, echo_valid, busy}, {e_done, e_err, e_echo, m_busy}); end
         tests++; if (value !== model_value() || digit_count !== CW'(m_digits.size())) begin
            fails++; $display("FAIL rnd_value got %h/%0d exp %h/%0d", value, digit_count, model_value(), m_digits.size()); end
         tests++; if ({status_code_out, usr_input_out, currency_type_out} !== {m_status, m_usr, m_cur}) begin
            fails++; $display("FAIL rnd_regs got %b exp %b", {status_code_out, usr_input_out, currency_type_out}, {m_status, m_usr, m_cur}); end
         if (e_echo) begin
            tests++; if (echo_char !== e_char) begin fails++; $display("FAIL rnd_echo got %h exp %h", echo_char, e_char); end
         end
         tests++; if (prev_done && done) begin fails++; $display("FAIL rnd_done_twice got 1 exp 0"); end
         prev_done = done;
      end
      rst_n = 1;
   endtask

   initial begin
      test_reset();
      test_acc_number();
      test_pin();
      test_backspace();
      test_overflow_and_reset();
      test_menu_currency();
      test_exit_and_drop();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
